// File: rtl/dm_pkg.sv
// Shared types and helpers for the data-memory responder: trace record
// layout, byte-enable constants and the byte-lane merge function.
package dm_pkg;

  localparam logic [3:0] BYTEEN_NONE = 4'b0000;
  localparam logic [3:0] BYTEEN_WORD = 4'b1111;

  // One committed store as seen by the trace consumer (96 bits).
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] addr;
    logic [31:0] data;
  } trace_rec_t;

  localparam trace_rec_t REC_ZERO = '{pc: 32'h0000_0000, addr: 32'h0000_0000, data: 32'h0000_0000};

  // Enabled lanes take the new data, the others keep the old word.
  function automatic logic [31:0] merge_lanes(input logic [31:0] old_word,
                                              input logic [31:0] wdata,
                                              input logic [3:0]  byteen);
    logic [31:0] res;
    res = old_word;
    for (int i = 0; i < 4; i++) begin
      if (byteen[i]) begin
        res[8*i +: 8] = wdata[8*i +: 8];
      end else begin
        res[8*i +: 8] = old_word[8*i +: 8];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/dm_responder_if.sv
// M-stage data bus plus the store-trace stream between the core side
// (master) and the data-memory responder (slave).
interface dm_responder_if;
  import dm_pkg::*;

  logic [31:0] m_data_addr;
  logic [31:0] m_data_wdata;
  logic [3:0]  m_data_byteen;
  logic [31:0] m_inst_addr;
  logic [31:0] m_data_rdata;
  logic        trace_valid;
  logic        trace_ready;
  logic [31:0] trace_pc;
  logic [31:0] trace_addr;
  logic [31:0] trace_data;
  logic        trace_overflow;
  logic        addr_err;

  modport master (
    output m_data_addr, m_data_wdata, m_data_byteen, m_inst_addr, trace_ready,
    input  m_data_rdata, trace_valid, trace_pc, trace_addr, trace_data,
           trace_overflow, addr_err
  );

  modport slave (
    input  m_data_addr, m_data_wdata, m_data_byteen, m_inst_addr, trace_ready,
    output m_data_rdata, trace_valid, trace_pc, trace_addr, trace_data,
           trace_overflow, addr_err
  );

endinterface

// File: rtl/dm_trace_fifo.sv
// Store-trace FIFO: first-word-fall-through from registers, drops the new
// record (and sets a sticky overflow flag) when full without a pop.
module dm_trace_fifo
  import dm_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push_i,
  input  trace_rec_t push_rec_i,
  input  logic       pop_req_i,
  output logic       valid_o,
  output trace_rec_t head_o,
  output logic       overflow_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  trace_rec_t         mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ovf_q, ovf_d;
  logic               empty_s, full_s, pop_s, do_push_s, drop_s;

  // Next-state: pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    empty_s   = (cnt_q == CNT_W'(0));
    full_s    = (cnt_q == CNT_W'(DEPTH));
    pop_s     = pop_req_i && !empty_s;
    do_push_s = push_i && (!full_s || pop_s);
    drop_s    = push_i && full_s && !pop_s;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q | drop_s;
    if (do_push_s) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({do_push_s, pop_s})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Control state register, cleared asynchronously.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= PTR_W'(0);
      rd_ptr_q <= PTR_W'(0);
      cnt_q    <= CNT_W'(0);
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
    end
  end

  // Record storage; contents only matter while counted as occupied.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_q[wr_ptr_q] <= push_rec_i;
    end
  end

  // Head outputs come only from registers and read as zero when empty.
  always_comb begin
    valid_o    = !empty_s;
    overflow_o = ovf_q;
    if (!empty_s) begin
      head_o = mem_q[rd_ptr_q];
    end else begin
      head_o = REC_ZERO;
    end
  end

endmodule

// File: rtl/dm_responder.sv
// Data-memory responder for the M stage: word store with byte-enable
// writes, combinational read, per-word written bits and a sticky
// out-of-range flag. Define DM_TRACE_EN to add the committed-store trace
// FIFO; without it the trace outputs are tied to zero.
module dm_responder
  import dm_pkg::*;
#(
  parameter int ADDR_WORDS  = 3072,
  parameter int TRACE_DEPTH = 8
) (
  input  logic           clk,
  input  logic           reset,
  dm_responder_if.slave  bus
);

  localparam int IDX_W = $clog2(ADDR_WORDS);

  logic [31:0]           mem_q [ADDR_WORDS];
  logic [ADDR_WORDS-1:0] written_q;
  logic                  addr_err_q, addr_err_d;
  logic [29:0]           word_idx_s;
  logic [IDX_W-1:0]      mem_idx_s;
  logic                  in_range_s;
  logic                  store_s;
  logic [31:0]           old_word_s;
  logic [31:0]           merged_s;
  logic                  unused_s;

  // Address decode, read path and store merge.
  always_comb begin
    word_idx_s = bus.m_data_addr[31:2];
    mem_idx_s  = word_idx_s[IDX_W-1:0];
    in_range_s = (word_idx_s < 30'(ADDR_WORDS));
    store_s    = in_range_s && (bus.m_data_byteen != BYTEEN_NONE);
    if (in_range_s && written_q[mem_idx_s]) begin
      old_word_s = mem_q[mem_idx_s];
    end else begin
      old_word_s = 32'h0000_0000;
    end
    merged_s = merge_lanes(old_word_s, bus.m_data_wdata, bus.m_data_byteen);
  end

  // Every cycle presents a read, so any out-of-range address is an error.
  always_comb begin
    if (!in_range_s) begin
      addr_err_d = 1'b1;
    end else begin
      addr_err_d = addr_err_q;
    end
  end

  // Word storage; unwritten words are masked by their written bit.
  always_ff @(posedge clk) begin
    if (store_s) begin
      mem_q[mem_idx_s] <= merged_s;
    end
  end

  // Written bits and sticky error flag, cleared asynchronously.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      written_q  <= {ADDR_WORDS{1'b0}};
      addr_err_q <= 1'b0;
    end else begin
      if (store_s) begin
        written_q[mem_idx_s] <= 1'b1;
      end
      addr_err_q <= addr_err_d;
    end
  end

  assign bus.m_data_rdata = old_word_s;
  assign bus.addr_err     = addr_err_q;

`ifdef DM_TRACE_EN
  trace_rec_t push_rec_s;
  trace_rec_t head_s;

  assign push_rec_s = '{pc:   bus.m_inst_addr,
                        addr: {bus.m_data_addr[31:2], 2'b00},
                        data: merged_s};

  dm_trace_fifo #(.DEPTH(TRACE_DEPTH)) u_trace_fifo (
    .clk        (clk),
    .reset      (reset),
    .push_i     (store_s),
    .push_rec_i (push_rec_s),
    .pop_req_i  (bus.trace_ready),
    .valid_o    (bus.trace_valid),
    .head_o     (head_s),
    .overflow_o (bus.trace_overflow)
  );

  assign bus.trace_pc   = head_s.pc;
  assign bus.trace_addr = head_s.addr;
  assign bus.trace_data = head_s.data;
  assign unused_s       = ^bus.m_data_addr[1:0];
`else
  assign bus.trace_valid    = 1'b0;
  assign bus.trace_pc       = 32'h0000_0000;
  assign bus.trace_addr     = 32'h0000_0000;
  assign bus.trace_data     = 32'h0000_0000;
  assign bus.trace_overflow = 1'b0;
  assign unused_s           = ^{bus.m_data_addr[1:0], bus.m_inst_addr, bus.trace_ready};
`endif

endmodule

// File: tb/tb_dm_responder.sv
// Directed bench for dm_responder: memory model plus a trace scoreboard
// queue filled when stores are driven and emptied as records drain.
module tb_dm_responder;
  import dm_pkg::*;

  localparam int ADDR_WORDS = 3072;
  localparam int DEPTH      = 8;
`ifdef DM_TRACE_EN
  localparam bit TRACE_ON = 1'b1;
`else
  localparam bit TRACE_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  int   n_pass = 0;
  int   n_fail = 0;
  int   n_total = 0;
  logic exp_ovf;
  logic exp_err;
  trace_rec_t  sb [$];
  logic [31:0] model [int];

  dm_responder_if bus ();

  dm_responder #(.ADDR_WORDS(ADDR_WORDS), .TRACE_DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  function automatic logic [31:0] model_read(input logic [31:0] a);
    int idx;
    idx = int'(a[31:2]);
    if (a[31:2] < 30'd3072 && model.exists(idx)) return model[idx];
    else return 32'h0000_0000;
  endfunction

  task automatic do_store(input logic [31:0] pc, input logic [31:0] a,
                          input logic [31:0] wd, input logic [3:0] be);
    logic [31:0] old_w;
    logic [31:0] new_w;
    bus.m_inst_addr   = pc;
    bus.m_data_addr   = a;
    bus.m_data_wdata  = wd;
    bus.m_data_byteen = be;
    #1;
    old_w = model_read(a);
    chk("same_cycle_read", bus.m_data_rdata, old_w);
    tick();
    bus.m_data_byteen = 4'b0000;
    if (a[31:2] < 30'd3072) begin
      if (be != 4'b0000) begin
        new_w = old_w;
        for (int i = 0; i < 4; i++) begin
          if (be[i]) new_w[8*i +: 8] = wd[8*i +: 8];
        end
        model[int'(a[31:2])] = new_w;
`ifdef DM_TRACE_EN
        if (sb.size() < DEPTH) sb.push_back('{pc: pc, addr: a & 32'hFFFF_FFFC, data: new_w});
        else exp_ovf = 1'b1;
`endif
      end
    end else begin
      exp_err = 1'b1;
    end
  endtask

  task automatic check_head(input string tag);
    trace_rec_t rec;
    rec = sb.pop_front();
    chk({tag, "_pc"},   bus.trace_pc,   rec.pc);
    chk({tag, "_addr"}, bus.trace_addr, rec.addr);
    chk({tag, "_data"}, bus.trace_data, rec.data);
  endtask

  task automatic drain(input string tag);
    int n;
    int popped;
    n = sb.size();
    popped = 0;
    bus.trace_ready = 1'b1;
    for (int c = 0; c < n + 4 && popped < n; c++) begin
      if (bus.trace_valid) begin
        check_head(tag);
        popped++;
      end
      tick();
    end
    bus.trace_ready = 1'b0;
    #1;
    chk({tag, "_count"}, 32'(popped), 32'(n));
    chk({tag, "_valid_after"}, {31'b0, bus.trace_valid}, 32'h0000_0000);
  endtask

  task automatic check_flags(input string tag);
    chk({tag, "_overflow"}, {31'b0, bus.trace_overflow}, {31'b0, exp_ovf});
    chk({tag, "_addr_err"}, {31'b0, bus.addr_err},       {31'b0, exp_err});
  endtask

  initial begin
    reset             = 1'b0;
    bus.m_data_addr   = 32'h0000_0010;
    bus.m_data_wdata  = 32'h0000_0000;
    bus.m_data_byteen = 4'b0000;
    bus.m_inst_addr   = 32'h0000_0000;
    bus.trace_ready   = 1'b0;
    exp_ovf           = 1'b0;
    exp_err           = 1'b0;

    // Reset state
    repeat (2) tick();
    chk("rst_rdata", bus.m_data_rdata, 32'h0000_0000);
    chk("rst_valid", {31'b0, bus.trace_valid}, 32'h0000_0000);
    check_flags("rst");
    reset = 1'b1;
    tick();
    chk("post_rst_rdata", bus.m_data_rdata, 32'h0000_0000);

    // Full-word store then read-back and trace record
    do_store(32'h0000_3000, 32'h0000_0010, 32'hDEAD_BEEF, 4'b1111);
    #1;
    chk("word_read", bus.m_data_rdata, 32'hDEAD_BEEF);
    chk("valid_after_store", {31'b0, bus.trace_valid}, {31'b0, TRACE_ON});
    drain("rec1");

    // Single-lane store at an unaligned address
    do_store(32'h0000_3004, 32'h0000_0011, 32'h0000_AB00, 4'b0010);
    bus.m_data_addr = 32'h0000_0010;
    #1;
    chk("lane_read", bus.m_data_rdata, 32'hDEAD_ABEF);
    chk("lane_trace_addr", bus.trace_addr, TRACE_ON ? 32'h0000_0010 : 32'h0000_0000);
    drain("rec2");

    // Fill to 8, then store and pop in the same cycle
    for (int i = 0; i < 8; i++)
      do_store(32'h0000_5000 + 32'(4*i), 32'h0000_0200 + 32'(4*i), 32'hA500_0000 + 32'(i), 4'b1111);
    chk("full_valid", {31'b0, bus.trace_valid}, {31'b0, TRACE_ON});
    bus.trace_ready = 1'b1;
    if (bus.trace_valid) check_head("simul_pop");
    do_store(32'h0000_5100, 32'h0000_0300, 32'hC0FF_EE00, 4'b1111);
    bus.trace_ready = 1'b0;
    #1;
    check_flags("simul");
    drain("simul_drain");

    // Nine stores into a depth-8 FIFO without draining
    for (int i = 0; i < 9; i++)
      do_store(32'h0000_4000 + 32'(4*i), 32'h0000_0400 + 32'(4*i), 32'h1111_0000 + 32'(i), 4'b1111);
    #1;
    check_flags("ovf");
    drain("ovf_drain");

    // Last legal word, then first illegal word
    do_store(32'h0000_6000, 32'h0000_2FFC, 32'h1234_5678, 4'b1111);
    #1;
    chk("last_word_read", bus.m_data_rdata, 32'h1234_5678);
    check_flags("last_word");
    drain("last_word_drain");
    do_store(32'h0000_6004, 32'h0000_3000, 32'hFFFF_FFFF, 4'b1111);
    bus.m_data_addr = 32'h0000_0010;
    #1;
    check_flags("oor");
    chk("oor_other_read", bus.m_data_rdata, 32'hDEAD_ABEF);
    chk("oor_no_trace", {31'b0, bus.trace_valid}, 32'h0000_0000);

    // Reset in the middle of a drain
    do_store(32'h0000_7000, 32'h0000_0020, 32'h0BAD_F00D, 4'b1111);
    do_store(32'h0000_7004, 32'h0000_0024, 32'h0000_0055, 4'b0001);
    bus.m_data_addr = 32'h0000_0010;
    bus.trace_ready = 1'b1;
    #1;
    if (bus.trace_valid) check_head("mid_drain");
    tick();
    reset = 1'b0;
    #1;
    chk("mid_rst_rdata", bus.m_data_rdata, 32'h0000_0000);
    chk("mid_rst_valid", {31'b0, bus.trace_valid}, 32'h0000_0000);
    chk("mid_rst_pc",    bus.trace_pc,   32'h0000_0000);
    chk("mid_rst_addr",  bus.trace_addr, 32'h0000_0000);
    chk("mid_rst_data",  bus.trace_data, 32'h0000_0000);
    sb.delete();
    model.delete();
    exp_ovf = 1'b0;
    exp_err = 1'b0;
    check_flags("mid_rst");
    tick();
    reset = 1'b1;
    bus.trace_ready = 1'b0;
    tick();
    chk("after_rst_rdata", bus.m_data_rdata, 32'h0000_0000);

    // Memory and trace work again after reset
    do_store(32'h0000_8000, 32'h0000_0010, 32'h7654_3210, 4'b1100);
    #1;
    chk("post_rst_store", bus.m_data_rdata, 32'h7654_0000);
    drain("post_rst");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
